siso_shift_ctrl: RTL and testbench
==================================

# siso_shift_ctrl

Sequencer for a DEPTH-stage serial-in/serial-out shift register. It accepts a WIDTH-bit parallel word over a valid/ready handshake and shifts it MSB-first into the register's serial input. It then flushes the register and reassembles the bits returning on the serial output into a parallel word, flagging whether they match what was sent. It sits between a parallel producer/consumer and the SISO register, and is the only driver of that register's shift enable and serial input.

## Interface
- WIDTH, 8, word length in bits; must be >= 2.
- DEPTH, 4, number of flip-flop stages in the attached SISO register; must be >= 1.

- clk  in  1  single clock; everything updates on its rising edge.
- rst  in  1  synchronous, active-high reset; the same rst also drives the attached SISO register.
- in_valid  in  1  producer has a word on in_data.
- in_ready  out  1  controller can accept a word.
- in_data  in  WIDTH  word to transmit.
- sr_en  out  1  shift enable to the SISO register.
- sr_si  out  1  serial data into the SISO register.
- sr_so  in  1  serial data out of the SISO register (last stage).
- out_valid  out  1  received word available.
- out_ready  in  1  consumer takes the received word.
- out_data  out  WIDTH  reassembled word, first received bit in the MSB.
- out_match  out  1  out_data equals the accepted in_data word.

## Operation
- States:
  - IDLE: in_ready=1, sr_en=0, sr_si=0, out_valid=0.
  - SHIFT: in_ready=0, sr_en=1.
  - DONE: in_ready=0, out_valid=1.
- IDLE -> SHIFT when in_valid && in_ready. Capture in_data into tx_reg and ref_reg, clear rx_reg, set cnt=0.
- In SHIFT, cnt counts enabled cycles 0 .. WIDTH+DEPTH-1. The counter is sized to clog2(WIDTH+DEPTH+1) bits.
- Cycles with cnt < WIDTH:
  - sr_si = tx_reg[WIDTH-1].
  - tx_reg shifts left by one at the edge.
- Cycles with cnt >= WIDTH: sr_si = 0 (flush padding).
- Cycles with cnt >= DEPTH: at the edge, rx_reg <= {rx_reg[WIDTH-2:0], sr_so}.
  - The bit launched in cycle j is visible on sr_so in cycle j+DEPTH.
- SHIFT -> DONE at the edge ending cnt = WIDTH+DEPTH-1.
- DONE:
  - out_data = rx_reg and out_match = (rx_reg == ref_reg). Both are registered and held stable while out_valid=1.
  - DONE -> IDLE at the edge where out_ready=1. out_data and out_match keep their last value after that.
- in_valid is ignored outside IDLE. in_data is sampled only on the accept edge.
- sr_si and sr_en are registered-state decodes. They must be glitch-free and change only after clock edges.
- Bits the register held before the accept are shifted out during cycles 0..DEPTH-1 and are not captured.

## Timing
- Reset (rst=1 at an edge) produces these values after that edge:
  - state=IDLE, cnt=0, tx_reg=0, rx_reg=0, ref_reg=0.
  - in_ready=1, sr_en=0, sr_si=0, out_valid=0, out_data=0, out_match=0.
- Reset applies from any state, including mid-SHIFT and DONE. The partial word is discarded and no out_valid is produced for it.
- Accept edge is E0.
  - sr_en is high for exactly WIDTH+DEPTH cycles, between edges E0 and E0+WIDTH+DEPTH.
  - out_valid rises after edge E0+WIDTH+DEPTH. With defaults this is 12 cycles.
- Consumption edge is Ec (out_valid && out_ready).
  - in_ready=1 in the cycle after Ec.
  - Earliest next accept is at edge Ec+1.
  - Steady-state throughput is one word per WIDTH+DEPTH+2 cycles.
- out_ready may be held high continuously; the DONE state still lasts one cycle minimum.
- Backpressure: with out_ready=0, DONE persists indefinitely, and out_valid, out_data and out_match stay constant.

## Test plan
- Loopback, WIDTH=8, DEPTH=4, attached to a 4-stage SISO model. Accept 0xA5.
  - sr_si over the 12 enabled cycles = 1,0,1,0,0,1,0,1,0,0,0,0.
  - out_valid rises 12 cycles after the accept with out_data=0xA5, out_match=1.
- Back-to-back: in_valid=1 with 0x3C, then 0xC3, and out_ready=1 held.
  - Both words are returned intact.
  - The second accept occurs exactly 14 edges after the first.
  - in_ready=0 throughout SHIFT and DONE.
- Backpressure: out_ready=0 for 5 cycles after out_valid rises.
  - out_valid, out_data and out_match are unchanged for those cycles; in_ready=0.
  - Raising out_ready gives in_ready=1 on the next cycle.
- Fault detection: sr_so tied to 0, accept 0xFF.
  - Result is out_data=0x00, out_match=0.
  - sr_en still pulses for exactly 12 cycles.
- Reset mid-operation: assert rst at SHIFT cycle cnt=3 for one edge.
  - After that edge all outputs are at reset values and in_ready=1.
  - No out_valid follows.
  - A fresh accept of 0x81 afterwards returns 0x81 with out_match=1.
- Ignored input: toggle in_valid and in_data during SHIFT.
  - The returned word equals the originally accepted word.
  - Exactly one out_valid pulse is produced.

Source files
------------

// File: rtl/siso_shift_ctrl.sv
// Sequencer for a DEPTH-stage SISO shift register: serialises a parallel word MSB-first,
// flushes the register, and reassembles the returning bits with a match flag.
module siso_shift_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             sr_en,
    output logic             sr_si,
    input  logic             sr_so,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_match
);

    localparam int CW = $clog2(WIDTH + DEPTH + 1);
    localparam logic [CW-1:0] W_C    = CW'(WIDTH);
    localparam logic [CW-1:0] D_C    = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_C = CW'(WIDTH + DEPTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  tx_reg;
    logic [WIDTH-1:0]  rx_reg;
    logic [WIDTH-1:0]  ref_reg;
    logic [WIDTH-1:0]  rx_next;

    assign rx_next = {rx_reg[WIDTH-2:0], sr_so};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            tx_reg    <= '0;
            rx_reg    <= '0;
            ref_reg   <= '0;
            in_ready  <= 1'b1;
            sr_en     <= 1'b0;
            sr_si     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_match <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state    <= SHIFT;
                        tx_reg   <= in_data;
                        ref_reg  <= in_data;
                        rx_reg   <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        sr_en    <= 1'b1;
                        sr_si    <= in_data[WIDTH-1];
                    end
                end
                SHIFT: begin
                    if (cnt < W_C)
                        tx_reg <= tx_reg << 1;
                    // The first DEPTH returning bits are stale register contents.
                    if (cnt >= D_C)
                        rx_reg <= rx_next;
                    if (cnt == LAST_C) begin
                        state     <= DONE;
                        sr_en     <= 1'b0;
                        sr_si     <= 1'b0;
                        out_valid <= 1'b1;
                        out_data  <= rx_next;
                        out_match <= (rx_next == ref_reg);
                    end else begin
                        cnt   <= cnt + 1'b1;
                        // Next cycle's serial bit: remaining payload MSB, else flush zero.
                        sr_si <= (cnt < W_C - 1'b1) ? tx_reg[WIDTH-2] : 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    sr_en     <= 1'b0;
                    sr_si     <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// Loopback bench: controller drives a behavioural 4-stage SISO register; results are
// compared against word-level expectations derived from the serial protocol.
module tb_siso_shift_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int NCYC  = WIDTH + DEPTH;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             sr_en;
    logic             sr_si;
    logic             sr_so;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_match;

    bit               fault;
    logic [DEPTH-1:0] q;

    always #5 clk = ~clk;

    siso_shift_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sr_en     (sr_en),
        .sr_si     (sr_si),
        .sr_so     (sr_so),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_match (out_match)
    );

    // Attached SISO register, sharing the controller's reset.
    always @(posedge clk) begin
        if (rst) q <= '0;
        else if (sr_en) q <= {q[DEPTH-2:0], sr_si};
    end
    assign sr_so = fault ? 1'b0 : q[DEPTH-1];

    int cyc = 0;
    int acc_q[$];
    always @(posedge clk) begin
        if (!rst && in_valid && in_ready) acc_q.push_back(cyc);
        cyc = cyc + 1;
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic send_word(input logic [7:0] data, input int bp, input bit noise,
                             output logic [7:0] d, output logic m, output int lat,
                             output int en_n, output logic [11:0] si);
        int w;
        bit bad;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        in_data  = data;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        lat = 0; en_n = 0; si = '0; bad = 0;
        while (!out_valid && lat < 100) begin
            if (sr_en) begin
                en_n++;
                si = {si[10:0], sr_si};
            end
            if (in_ready) bad = 1;
            if (noise) begin
                in_valid = 1'($urandom);
                in_data  = 8'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        chk("in_ready_low_in_shift", bad, 0);
        chk("out_valid_rise", out_valid, 1);
        d = out_data;
        m = out_match;
        bad = 0;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            if (!out_valid || out_data !== d || out_match !== m || in_ready || sr_en) bad = 1;
        end
        chk("backpressure_hold", bad, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("in_ready_after_consume", in_ready, 1);
        chk("out_valid_after_consume", out_valid, 0);
        chk("out_data_kept", out_data, d);
    endtask

    typedef struct {
        logic [7:0] data;
        int         bp;
        bit         flt;
        logic [7:0] exp_d;
        bit         exp_m;
    } vec_t;

    vec_t       vt[5];
    logic [7:0] d, ed, got[$];
    logic       m, em;
    logic [11:0] si;
    int         lat, en_n, nv;
    bit         bad;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        vt[0] = '{8'hA5, 0, 1'b0, 8'hA5, 1'b1};
        vt[1] = '{8'hFF, 0, 1'b1, 8'h00, 1'b0};
        vt[2] = '{8'h3C, 5, 1'b0, 8'h3C, 1'b1};
        vt[3] = '{8'h00, 2, 1'b0, 8'h00, 1'b1};
        vt[4] = '{8'h81, 1, 1'b1, 8'h00, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; fault = 0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sr_en", sr_en, 0);
        chk("rst_sr_si", sr_si, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_match", out_match, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        foreach (vt[i]) begin
            fault = vt[i].flt;
            send_word(vt[i].data, vt[i].bp, 1'b0, d, m, lat, en_n, si);
            chk("vec_out_data", d, vt[i].exp_d);
            chk("vec_out_match", m, vt[i].exp_m);
            chk("vec_latency", lat, NCYC);
            chk("vec_sr_en_cycles", en_n, NCYC);
            chk("vec_sr_si_seq", si, {vt[i].data, 4'h0});
        end
        fault = 0;

        // Back-to-back with out_ready held high.
        acc_q.delete(); got.delete(); bad = 0;
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h3C;
        for (int i = 0; i < 80 && got.size() < 2; i++) begin
            @(negedge clk);
            if (acc_q.size() == 1) in_data = 8'hC3;
            if (acc_q.size() >= 2) in_valid = 1'b0;
            if (out_valid) got.push_back(out_data);
            if (in_ready && (sr_en || out_valid)) bad = 1;
        end
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b0;
        chk("b2b_word_count", got.size(), 2);
        chk("b2b_accept_count", acc_q.size(), 2);
        if (got.size() == 2) begin
            chk("b2b_word0", got[0], 8'h3C);
            chk("b2b_word1", got[1], 8'hC3);
        end
        if (acc_q.size() == 2) chk("b2b_accept_gap", acc_q[1] - acc_q[0], NCYC + 2);
        chk("b2b_in_ready_low", bad, 0);

        // Reset in the middle of SHIFT at cnt=3.
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'hAA;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_sr_en", sr_en, 0);
        chk("midrst_sr_si", sr_si, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_out_match", out_match, 0);
        nv = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        chk("midrst_no_out_valid", nv, 0);
        send_word(8'h81, 0, 1'b0, d, m, lat, en_n, si);
        chk("midrst_fresh_data", d, 8'h81);
        chk("midrst_fresh_match", m, 1);

        // Input activity during SHIFT must be ignored.
        send_word(8'h5A, 0, 1'b1, d, m, lat, en_n, si);
        chk("noise_data", d, 8'h5A);
        chk("noise_match", m, 1);
        nv = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        chk("noise_single_pulse", nv, 0);

        // Randomised words against the word-level loopback model.
        for (int k = 0; k < 25; k++) begin
            logic [7:0] data;
            int bp;
            data  = 8'($urandom);
            bp    = $urandom_range(0, 3);
            fault = ($urandom_range(0, 3) == 0);
            ed    = fault ? 8'h00 : data;
            em    = (ed == data);
            send_word(data, bp, 1'b0, d, m, lat, en_n, si);
            chk("rnd_out_data", d, ed);
            chk("rnd_out_match", m, em);
            chk("rnd_latency", lat, NCYC);
            chk("rnd_sr_en_cycles", en_n, NCYC);
            chk("rnd_sr_si_seq", si, {data, 4'h0});
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
